voq_req_gen: RTL and testbench

VOQ_REQ_GEN -- requirements
Module: voq_req_gen

---
 rtl/voq_req_gen.sv | 148 ++++++++++++++
 tb/tb_voq_req_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/voq_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : voq_req_gen
// Purpose  : Virtual-output-queue occupancy tracker and request generator.
//            Keeps one occupancy counter per (source, destination) pair,
//            counts cell arrivals in and scheduler grants out, and presents
//            a registered request matrix (one bit per non-empty VOQ) to the
//            scheduler together with the total number of queued cells.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous active-low reset
//   arr_valid     in   1          cell arrival offered this cycle
//   arr_ready     out  1          offered arrival is accepted (combinational)
//   arr_src       in   LOG_W      arrival source index
//   arr_dst       in   LOG_W      arrival destination index
//   gnt_valid     in   1          Gnt is valid this cycle
//   Gnt           in   N*N        grant matrix, bit s*N+d = source s, dest d
//   Req           out  N*N        registered request matrix (VOQ non-empty)
//   occ_total     out  2*LOG_W+CNT_W  registered total queued cells
//   err_gnt_empty out  1          sticky: a valid grant hit an empty VOQ
//   flush         in   1          synchronous clear of all VOQ state
// ============================================================================
module voq_req_gen #(
  parameter int PPE_WIDTH = 8,
  parameter int PPE_LOG_W = 3,
  parameter int CNT_W     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arr_valid,
  output logic                                 arr_ready,
  input  logic [PPE_LOG_W-1:0]                 arr_src,
  input  logic [PPE_LOG_W-1:0]                 arr_dst,
  input  logic                                 gnt_valid,
  input  logic [PPE_WIDTH*PPE_WIDTH-1:0]       Gnt,
  output logic [PPE_WIDTH*PPE_WIDTH-1:0]       Req,
  output logic [PPE_LOG_W*2+CNT_W-1:0]         occ_total,
  output logic                                 err_gnt_empty,
  input  logic                                 flush
);

  localparam int                c_NN      = PPE_WIDTH * PPE_WIDTH;
  localparam int                c_K_W     = 2 * PPE_LOG_W;
  localparam int                c_OCC_W   = PPE_LOG_W * 2 + CNT_W;
  localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]   r_cnt [c_NN];
  logic [c_NN-1:0]    r_req;
  logic [c_OCC_W-1:0] r_occ;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Arrival acceptance
  // --------------------------------------------------------------------------
  // PPE_WIDTH is a power of two, so src*N+dst is plain concatenation.
  logic [c_K_W-1:0] w_k;
  logic             w_k_full;
  logic             w_k_gnt;
  logic             w_accept;

  assign w_k      = {arr_src, arr_dst};
  assign w_k_full = (r_cnt[w_k] == c_CNT_MAX);
  // A full VOQ can still take a cell if a cell leaves it in the same cycle.
  assign w_k_gnt  = gnt_valid & Gnt[w_k];

  // Held low in reset and during flush so nothing upstream believes a cell
  // was taken while state is being cleared.
  assign arr_ready = rst_n & ~flush & (~w_k_full | w_k_gnt);
  assign w_accept  = arr_valid & arr_ready;

  // --------------------------------------------------------------------------
  // Per-VOQ next-count computation
  // --------------------------------------------------------------------------
  logic [c_NN-1:0]  w_inc;
  logic [c_NN-1:0]  w_dec;
  logic [c_NN-1:0]  w_gnt_empty;
  logic [CNT_W-1:0] w_cnt_nxt [c_NN];

  for (genvar j = 0; j < c_NN; j++) begin : g_voq
    assign w_inc[j]       = w_accept & (w_k == c_K_W'(j));
    // Only a non-empty VOQ can be decremented; a grant on an empty one is an
    // error event and never underflows the counter.
    assign w_dec[j]       = gnt_valid & Gnt[j] & (r_cnt[j] != '0);
    assign w_gnt_empty[j] = gnt_valid & Gnt[j] & (r_cnt[j] == '0);

    // Arrival and grant on the same VOQ cancel; the count (and so Req) holds.
    assign w_cnt_nxt[j] = ( w_inc[j] & ~w_dec[j]) ? r_cnt[j] + CNT_W'(1) :
                          (~w_inc[j] &  w_dec[j]) ? r_cnt[j] - CNT_W'(1) :
                                                    r_cnt[j];
  end

  // --------------------------------------------------------------------------
  // Occupancy total: +1 per accepted arrival, -1 per effective decrement.
  // The width covers N*N*(2^CNT_W-1), so no wrap is possible.
  // --------------------------------------------------------------------------
  logic [c_OCC_W-1:0] w_dec_cnt;
  logic [c_OCC_W-1:0] w_occ_nxt;

  always_comb begin
    w_dec_cnt = '0;
    for (int i = 0; i < c_NN; i++) begin
      w_dec_cnt = w_dec_cnt + c_OCC_W'(w_dec[i]);
    end
  end

  assign w_occ_nxt = r_occ + c_OCC_W'(w_accept) - w_dec_cnt;

  // --------------------------------------------------------------------------
  // Registers. Req is derived from the next count so a cell accepted in
  // cycle t requests in t+1, and a VOQ emptied in t drops its request in t+1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NN; i++) begin
        r_cnt[i] <= '0;
      end
      r_req <= '0;
      r_occ <= '0;
      r_err <= 1'b0;
    end else if (flush) begin
      // Flush wins over any same-cycle arrival or grant.
      for (int i = 0; i < c_NN; i++) begin
        r_cnt[i] <= '0;
      end
      r_req <= '0;
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < c_NN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_req[i] <= (w_cnt_nxt[i] != '0);
      end
      r_occ <= w_occ_nxt;
      r_err <= r_err | (|w_gnt_empty);
    end
  end

  assign Req           = r_req;
  assign occ_total     = r_occ;
  assign err_gnt_empty = r_err;

endmodule
`default_nettype wire

// File: tb/tb_voq_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_voq_req_gen
// Purpose  : Self-checking bench for voq_req_gen (N=8, CNT_W=4). A table of
//            single-cycle vectors with hand-computed results, followed by
//            hand-written fill/drain, flush and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voq_req_gen;

  localparam int N     = 8;
  localparam int LOG_W = 3;
  localparam int CW    = 4;

  localparam logic [63:0] B0  = 64'd1 << 0;
  localparam logic [63:0] B3  = 64'd1 << 3;
  localparam logic [63:0] B9  = 64'd1 << 9;
  localparam logic [63:0] B12 = 64'd1 << 12;
  localparam logic [63:0] B21 = 64'd1 << 21;
  localparam logic [63:0] B40 = 64'd1 << 40;
  localparam logic [63:0] B63 = 64'd1 << 63;

  logic              clk;
  logic              rst_n;
  logic              arr_valid;
  logic              arr_ready;
  logic [LOG_W-1:0]  arr_src;
  logic [LOG_W-1:0]  arr_dst;
  logic              gnt_valid;
  logic [N*N-1:0]    Gnt;
  logic [N*N-1:0]    Req;
  logic [LOG_W*2+CW-1:0] occ_total;
  logic              err_gnt_empty;
  logic              flush;

  voq_req_gen #(
    .PPE_WIDTH (N),
    .PPE_LOG_W (LOG_W),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arr_valid     (arr_valid),
    .arr_ready     (arr_ready),
    .arr_src       (arr_src),
    .arr_dst       (arr_dst),
    .gnt_valid     (gnt_valid),
    .Gnt           (Gnt),
    .Req           (Req),
    .occ_total     (occ_total),
    .err_gnt_empty (err_gnt_empty),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic ready_seen;

  typedef struct {
    logic        av;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        gv;
    logic [63:0] gnt;
    logic        exp_ready;
    logic [63:0] exp_req;
    logic [9:0]  exp_occ;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, sample arr_ready before the
  // edge, let the edge happen, then return inputs to idle.
  task automatic step(input logic av, input logic [2:0] src, input logic [2:0] dst,
                      input logic gv, input logic [63:0] g, input logic fl);
    @(negedge clk);
    arr_valid = av;
    arr_src   = src;
    arr_dst   = dst;
    gnt_valid = gv;
    Gnt       = g;
    flush     = fl;
    #1;
    ready_seen = arr_ready;
    @(posedge clk);
    #1;
    arr_valid = 1'b0;
    gnt_valid = 1'b0;
    Gnt       = '0;
    flush     = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    arr_valid = 1'b0;
    arr_src   = '0;
    arr_dst   = '0;
    gnt_valid = 1'b0;
    Gnt       = '0;
    flush     = 1'b0;

    //            av    src   dst   gv    gnt        rdy   req              occ     err
    vecs[0]  = '{1'b1, 3'd2, 3'd5, 1'b0, 64'd0,     1'b1, B21,             10'd1,  1'b0};
    vecs[1]  = '{1'b1, 3'd1, 3'd1, 1'b0, 64'd0,     1'b1, B21|B9,          10'd2,  1'b0};
    vecs[2]  = '{1'b1, 3'd1, 3'd1, 1'b1, B9,        1'b1, B21|B9,          10'd2,  1'b0};
    vecs[3]  = '{1'b0, 3'd0, 3'd0, 1'b1, B40,       1'b1, B21|B9,          10'd2,  1'b1};
    vecs[4]  = '{1'b1, 3'd0, 3'd3, 1'b0, 64'd0,     1'b1, B21|B9|B3,       10'd3,  1'b1};
    vecs[5]  = '{1'b1, 3'd1, 3'd4, 1'b0, 64'd0,     1'b1, B21|B9|B3|B12,   10'd4,  1'b1};
    vecs[6]  = '{1'b0, 3'd0, 3'd0, 1'b1, B3|B12,    1'b1, B21|B9,          10'd2,  1'b1};
    vecs[7]  = '{1'b0, 3'd0, 3'd0, 1'b0, B21,       1'b1, B21|B9,          10'd2,  1'b1};
    vecs[8]  = '{1'b0, 3'd0, 3'd0, 1'b1, B21|B9,    1'b1, 64'd0,           10'd0,  1'b1};
    vecs[9]  = '{1'b1, 3'd7, 3'd7, 1'b0, 64'd0,     1'b1, B63,             10'd1,  1'b1};
    vecs[10] = '{1'b0, 3'd0, 3'd0, 1'b1, B63,       1'b1, 64'd0,           10'd0,  1'b1};

    // Reset state
    #12;
    check("rst_req", Req, 64'd0);
    check("rst_occ", 64'(occ_total), 64'd0);
    check("rst_err", 64'(err_gnt_empty), 64'd0);
    arr_valid = 1'b1;
    #1;
    check("rst_ready", 64'(arr_ready), 64'd0);
    arr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].av, vecs[i].src, vecs[i].dst, vecs[i].gv, vecs[i].gnt, 1'b0);
      check($sformatf("v%0d_ready", i), 64'(ready_seen), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_req", i), Req, vecs[i].exp_req);
      check($sformatf("v%0d_occ", i), 64'(occ_total), 64'(vecs[i].exp_occ));
      check($sformatf("v%0d_err", i), 64'(err_gnt_empty), 64'(vecs[i].exp_err));
    end

    // Fill k=0 to 15 cells
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 3'd0, 3'd0, 1'b0, 64'd0, 1'b0);
      check($sformatf("fill%0d_ready", i), 64'(ready_seen), 64'd1);
    end
    check("fill_occ", 64'(occ_total), 64'd15);
    check("fill_req", Req, B0);
    // 16th offer refused
    step(1'b1, 3'd0, 3'd0, 1'b0, 64'd0, 1'b0);
    check("full_ready", 64'(ready_seen), 64'd0);
    check("full_occ", 64'(occ_total), 64'd15);
    // Offer with same-cycle grant accepted, count stays at 15
    step(1'b1, 3'd0, 3'd0, 1'b1, B0, 1'b0);
    check("fullgnt_ready", 64'(ready_seen), 64'd1);
    check("fullgnt_occ", 64'(occ_total), 64'd15);
    check("fullgnt_req", Req, B0);
    step(1'b1, 3'd0, 3'd0, 1'b0, 64'd0, 1'b0);
    check("stillfull_ready", 64'(ready_seen), 64'd0);
    // Drain
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 3'd0, 3'd0, 1'b1, B0, 1'b0);
    end
    check("drain_occ", 64'(occ_total), 64'd0);
    check("drain_req", Req, 64'd0);
    check("drain_err", 64'(err_gnt_empty), 64'd1);

    // Flush with 5 cells queued and a same-cycle arrival
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd2, 3'd5, 1'b0, 64'd0, 1'b0);
    end
    check("preflush_occ", 64'(occ_total), 64'd5);
    step(1'b1, 3'd2, 3'd5, 1'b1, B21, 1'b1);
    check("flush_ready", 64'(ready_seen), 64'd0);
    check("flush_req", Req, 64'd0);
    check("flush_occ", 64'(occ_total), 64'd0);
    check("flush_err", 64'(err_gnt_empty), 64'd0);
    step(1'b1, 3'd2, 3'd5, 1'b0, 64'd0, 1'b0);
    check("postflush_occ", 64'(occ_total), 64'd1);
    check("postflush_req", Req, B21);

    // Asynchronous reset mid-cycle with 5 cells queued and err set
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd2, 3'd5, 1'b0, 64'd0, 1'b0);
    end
    step(1'b0, 3'd0, 3'd0, 1'b1, B40, 1'b0);
    check("prerst_occ", 64'(occ_total), 64'd5);
    check("prerst_err", 64'(err_gnt_empty), 64'd1);
    #2;
    arr_valid = 1'b1;
    arr_src   = 3'd2;
    arr_dst   = 3'd5;
    rst_n     = 1'b0;
    #1;
    check("arst_req", Req, 64'd0);
    check("arst_occ", 64'(occ_total), 64'd0);
    check("arst_err", 64'(err_gnt_empty), 64'd0);
    check("arst_ready", 64'(arr_ready), 64'd0);
    @(posedge clk);
    #1;
    check("arst_hold_occ", 64'(occ_total), 64'd0);
    @(negedge clk);
    arr_valid = 1'b0;
    rst_n     = 1'b1;
    step(1'b1, 3'd2, 3'd5, 1'b0, 64'd0, 1'b0);
    check("postrst_occ", 64'(occ_total), 64'd1);
    check("postrst_req", Req, B21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
